dac_sigma_delta_tx: RTL and testbench
=====================================

// Module: dac_sigma_delta_tx
// PURPOSE
//   Transmit side of the paddle analogue link: converts a WIDTH-bit code into a
//   first-order sigma-delta bitstream on DACout, which is RC-filtered off-chip.
//   Accepts codes over a valid/ready handshake and holds each code for SETTLE_CYCLES.
//   It then pulses settled, telling the successive-approximation ADC controller that
//   the filtered level may now be compared. Sits between the ADC controller and the
//   DAC output pin.
// PARAMETERS
//   WIDTH          7    code width; the modulator period is 2^WIDTH cycles
//   SETTLE_CYCLES  128  cycles a new code is held before settled; legal range >= 2
//   IDLE_CODE      0    code driven after reset, until the first transfer
// PORTS
//   CLK        in   1      system clock; all logic on the rising edge
//   nReset     in   1      asynchronous, active-low reset
//   dataIn     in   WIDTH  code to transmit
//   dataValid  in   1      dataIn is valid
//   dataReady  out  1      block can accept a code
//   DACout     out  1      sigma-delta bitstream to the external RC filter
//   code       out  WIDTH  code currently being modulated
//   busy       out  1      high while a code is settling
//   settled    out  1      one-cycle pulse when settling completes
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, acc=0, DACout=0, code=IDLE_CODE,
//     dataReady=1, busy=0, settled=0, cnt=0. Asserting reset mid-SETTLE aborts at once;
//     no settled pulse is produced for the aborted code.
//   Modulator: runs every cycle in every state using the registered code.
//     It uses a WIDTH+1-bit sum, s = {1'b0,acc} + {1'b0,code}.
//     acc <= s[WIDTH-1:0]; DACout <= s[WIDTH] (registered).
//     acc is NOT cleared on a code change, so the bitstream stays continuous.
//     For a constant code held for any 2^WIDTH consecutive cycles, DACout is high
//       exactly `code` times, whatever the starting acc.
//     code=0 gives DACout constant 0. code=2^WIDTH-1 gives one 0 per 2^WIDTH cycles.
//   FSM:
//     IDLE: dataReady=1, busy=0. If dataValid at the edge, accept the transfer.
//       On acceptance: code<=dataIn, cnt<=SETTLE_CYCLES-1, dataReady<=0, busy<=1,
//       and the state moves to SETTLE.
//     SETTLE: dataValid and dataIn are ignored. If cnt!=0, cnt<=cnt-1.
//       If cnt==0: settled<=1 for exactly one cycle, dataReady<=1, busy<=0,
//       and the state returns to IDLE.
//   Timing: a transfer accepted at edge k gives settled high for the cycle after edge
//     k+SETTLE_CYCLES. The new code affects DACout from edge k+1.
//   Back-to-back: dataReady rises in the same cycle as settled, so a held dataValid is
//     accepted on the next edge. Throughput is 1 code per SETTLE_CYCLES+1 cycles.
//   cnt width is clog2(SETTLE_CYCLES). code and dataIn are unsigned, with no saturation.
// TESTING
//   1 Reset: pulse nReset low mid-clock -> outputs take reset values immediately.
//     DACout stays 0 for 256 cycles (IDLE_CODE=0).
//   2 Density: send code 32, then count DACout highs over cycles k+1..k+128 -> exactly 32.
//     Repeat with code 127 -> exactly 127 highs.
//   3 Handshake timing: accept code 100 at edge k -> dataReady low at k+1.
//     settled is a single pulse after edge k+128, with dataReady and busy updated together.
//   4 Ignore while busy: during SETTLE, drive dataValid=1 with dataIn=5.
//     -> code stays 100; no extra settled pulse.
//   5 Back-to-back: hold dataValid=1 with codes 10, then 20.
//     -> second accept exactly 129 cycles after the first; code becomes 20.
//   6 Reset mid-SETTLE: assert nReset 40 cycles after accepting code 64.
//     -> no settled pulse; code=0, dataReady=1 after release.

Source files
------------

// File: rtl/dac_sigma_delta_tx_if.sv
// rtl/dac_sigma_delta_tx_if.sv - code transfer handshake between ADC controller and DAC transmitter
// Signals:
//   dataIn     code to transmit (master -> slave)
//   dataValid  dataIn is valid (master -> slave)
//   dataReady  transmitter can accept a code (slave -> master)
interface dac_sigma_delta_tx_if #(
    parameter int WIDTH = 7
);
    logic [WIDTH-1:0] dataIn;
    logic             dataValid;
    logic             dataReady;

    modport master (
        output dataIn,
        output dataValid,
        input  dataReady
    );

    modport slave (
        input  dataIn,
        input  dataValid,
        output dataReady
    );
endinterface

// File: rtl/dac_sigma_delta_tx.sv
// rtl/dac_sigma_delta_tx.sv - first-order sigma-delta DAC transmitter with settle timer
// Ports:
//   CLK      in   system clock, rising edge
//   nReset   in   asynchronous active-low reset
//   bus      slave handshake (dataIn, dataValid, dataReady)
//   DACout   out  registered sigma-delta bitstream to the off-chip RC filter
//   code     out  code currently being modulated
//   busy     out  high while a code is settling
//   settled  out  one-cycle pulse when settling completes
module dac_sigma_delta_tx #(
    parameter int               WIDTH         = 7,
    parameter int               SETTLE_CYCLES = 128,
    parameter logic [WIDTH-1:0] IDLE_CODE     = '0
) (
    input  logic                  CLK,
    input  logic                  nReset,
    dac_sigma_delta_tx_if.slave   bus,
    output logic                  DACout,
    output logic [WIDTH-1:0]      code,
    output logic                  busy,
    output logic                  settled
);

    localparam int               CNT_W    = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SETTLE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;
    logic             ready_q;

    assign bus.dataReady = ready_q;

    // The carry out of the accumulator is the output bit; acc keeps running across
    // code changes so the filtered level moves without a glitch.
    assign sum = {1'b0, acc} + {1'b0, code};

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            acc    <= '0;
            DACout <= 1'b0;
        end else begin
            acc    <= sum[WIDTH-1:0];
            DACout <= sum[WIDTH];
        end
    end

    always_ff @(posedge CLK or negedge nReset) begin
        if (!nReset) begin
            state   <= ST_IDLE;
            code    <= IDLE_CODE;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            settled <= 1'b0;
        end else begin
            settled <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.dataValid) begin
                        code    <= bus.dataIn;
                        cnt     <= CNT_LOAD;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    // Inputs are ignored here; the ADC controller must see settled first.
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        settled <= 1'b1;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sigma_delta_tx.sv
// tb/tb_dac_sigma_delta_tx.sv - self-checking bench for dac_sigma_delta_tx
module tb_dac_sigma_delta_tx;

    localparam int W      = 7;
    localparam int SETTLE = 128;
    localparam int MOD    = 1 << W;

    logic         CLK = 1'b0;
    logic         nReset = 1'b0;
    logic         DACout;
    logic [W-1:0] code;
    logic         busy;
    logic         settled;

    int checks = 0;
    int failures = 0;

    dac_sigma_delta_tx_if #(.WIDTH(W)) bus ();

    dac_sigma_delta_tx #(
        .WIDTH(W),
        .SETTLE_CYCLES(SETTLE),
        .IDLE_CODE('0)
    ) dut (
        .CLK(CLK),
        .nReset(nReset),
        .bus(bus.slave),
        .DACout(DACout),
        .code(code),
        .busy(busy),
        .settled(settled)
    );

    always #5 CLK = ~CLK;

    // Reference model: arithmetic accumulator plus an "accepted at edge N" timeline.
    int m_acc, m_code, m_dac, m_busy, m_settled, m_accept_edge;
    int edge_n = 0;
    int accepted = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_code = 0; m_dac = 0; m_busy = 0; m_settled = 0; m_accept_edge = 0;
    endtask

    task automatic model_edge();
        int s;
        s = m_acc + m_code;
        m_dac = (s >= MOD) ? 1 : 0;
        m_acc = s % MOD;
        m_settled = 0;
        accepted = 0;
        if (m_busy != 0) begin
            if (edge_n - m_accept_edge == SETTLE) begin
                m_busy = 0;
                m_settled = 1;
            end
        end else if (bus.dataValid) begin
            m_code = int'(bus.dataIn);
            m_busy = 1;
            m_accept_edge = edge_n;
            accepted = 1;
        end
    endtask

    task automatic compare();
        check("DACout",    int'(DACout),        m_dac);
        check("code",      int'(code),          m_code);
        check("dataReady", int'(bus.dataReady), (m_busy != 0) ? 0 : 1);
        check("busy",      int'(busy),          m_busy);
        check("settled",   int'(settled),       m_settled);
    endtask

    // One clock: model advances on the edge, DUT is compared on the falling edge.
    task automatic step();
        @(posedge CLK);
        edge_n++;
        if (nReset) model_edge();
        @(negedge CLK);
        compare();
    endtask

    task automatic mid_cycle_reset();
        #2 nReset = 1'b0;
        model_reset();
        #1;
        check("rst_dataReady", int'(bus.dataReady), 1);
        check("rst_busy",      int'(busy),          0);
        check("rst_settled",   int'(settled),       0);
        check("rst_DACout",    int'(DACout),        0);
        check("rst_code",      int'(code),          0);
        #1 nReset = 1'b1;
    endtask

    task automatic send(input int c);
        int n;
        bus.dataIn = W'(c);
        bus.dataValid = 1'b1;
        n = 0;
        accepted = 0;
        while (accepted == 0 && n < 300) begin
            step();
            n++;
        end
        check("send_accepted", accepted, 1);
        bus.dataValid = 1'b0;
    endtask

    int highs, pulses, pos, first_acc, second_acc;

    initial begin
        bus.dataIn = '0;
        bus.dataValid = 1'b0;
        model_reset();
        #13 nReset = 1'b1;
        @(negedge CLK);
        compare();

        // Reset from a non-idle state, then code 0 must give a silent bitstream.
        send(50);
        repeat (10) step();
        mid_cycle_reset();
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            highs += int'(DACout);
        end
        check("idle_highs_256", highs, 0);

        // Density over one modulator period.
        send(32);
        highs = 0;
        for (int i = 0; i < SETTLE; i++) begin
            step();
            highs += int'(DACout);
        end
        check("density_32", highs, 32);
        send(127);
        highs = 0;
        for (int i = 0; i < SETTLE; i++) begin
            step();
            highs += int'(DACout);
        end
        check("density_127", highs, 127);

        // Handshake timing and ignore-while-busy.
        send(100);
        check("ready_low_after_accept", int'(bus.dataReady), 0);
        bus.dataIn = W'(5);
        bus.dataValid = 1'b1;
        pulses = 0;
        pos = -1;
        for (int i = 1; i <= 135; i++) begin
            if (i == 100) bus.dataValid = 1'b0;
            step();
            if (i <= SETTLE) check("code_held_100", int'(code), 100);
            if (settled) begin
                pulses++;
                if (pos < 0) begin
                    pos = i;
                    check("settle_ready", int'(bus.dataReady), 1);
                    check("settle_busy", int'(busy), 0);
                end
            end
        end
        check("settle_pos", pos, 128);
        check("settle_pulses", pulses, 1);

        // Back-to-back with dataValid held.
        bus.dataIn = W'(10);
        bus.dataValid = 1'b1;
        accepted = 0;
        for (int n = 0; n < 20 && accepted == 0; n++) step();
        first_acc = edge_n;
        bus.dataIn = W'(20);
        accepted = 0;
        for (int n = 0; n < 300 && accepted == 0; n++) step();
        second_acc = edge_n;
        check("b2b_gap", second_acc - first_acc, SETTLE + 1);
        check("b2b_code", int'(code), 20);
        bus.dataValid = 1'b0;
        repeat (SETTLE + 2) step();

        // Reset mid-settle: no settled pulse for the aborted code.
        send(64);
        repeat (40) step();
        mid_cycle_reset();
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            pulses += int'(settled);
        end
        check("abort_pulses", pulses, 0);
        check("abort_code", int'(code), 0);
        check("abort_ready", int'(bus.dataReady), 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bus.dataValid = ($urandom_range(0, 2) == 0);
            bus.dataIn = W'($urandom);
            step();
        end
        bus.dataValid = 1'b0;
        repeat (SETTLE + 2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
